// File: rtl/matrix_row_streamer_if.sv
// Element stream from the row streamer to the Ethernet packetizer.
// Valid/ready handshake with per-row and per-frame end markers.
interface matrix_row_streamer_if #(
  parameter int ELEM_WIDTH = 8
);
  logic [ELEM_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_row_last;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready,
    output m_row_last,
    output m_last
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_row_last,
    input  m_last
  );
endinterface

// File: rtl/matrix_row_streamer.sv
// Port-B reader of the product-matrix BRAM: reads rows through the
// 2-cycle registered read port and streams them out element by element.
module matrix_row_streamer #(
  parameter int ELEM_WIDTH    = 8,
  parameter int ELEMS_PER_ROW = 4,
  parameter int RAM_DEPTH     = 16,
  parameter int ADDR_W        = $clog2(RAM_DEPTH),
  parameter int CNT_W         = $clog2(ELEMS_PER_ROW + 1)
) (
  input  logic                                eth_refclk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_W:0]                     num_rows,
  input  logic [CNT_W-1:0]                    num_elems,
  output logic [ADDR_W-1:0]                   bram_addr,
  output logic                                bram_en,
  output logic                                bram_regce,
  input  logic [ELEM_WIDTH*ELEMS_PER_ROW-1:0] bram_dout,
  matrix_row_streamer_if.master               m,
  output logic                                busy,
  output logic                                done
);

  localparam int RW = ELEM_WIDTH * ELEMS_PER_ROW;
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [CNT_W-1:0] EPR_C   = CNT_W'(ELEMS_PER_ROW);
  localparam logic [CNT_W-1:0] E_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]  R_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT1,
    S_WAIT2,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [CNT_W-1:0]  elem_q, elem_d;
  logic [ADDR_W:0]   rows_l_q, rows_l_d;
  logic [CNT_W-1:0]  elems_l_q, elems_l_d;
  logic [RW-1:0]     rowbuf_q, rowbuf_d;

  logic [ADDR_W:0]   rows_clamp;
  logic              last_elem;
  logic              last_row;
  logic              hs;

  assign rows_clamp = (num_rows > DEPTH_C) ? DEPTH_C : num_rows;
  assign last_elem  = (elem_q == elems_l_q - E_ONE);
  assign last_row   = ({1'b0, row_q} == rows_l_q - R_ONE);
  assign hs         = m.m_valid & m.m_ready;

  // State and datapath registers; reset abandons any transfer.
  always_ff @(posedge eth_refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      elem_q    <= '0;
      rows_l_q  <= '0;
      elems_l_q <= '0;
      rowbuf_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      elem_q    <= elem_d;
      rows_l_q  <= rows_l_d;
      elems_l_q <= elems_l_d;
      rowbuf_q  <= rowbuf_d;
    end
  end

  // Next-state, counter updates and all outputs decoded from state.
  // The row buffer shifts down one element per beat, so the current
  // element always sits in the low bits.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    elem_d       = elem_q;
    rows_l_d     = rows_l_q;
    elems_l_d    = elems_l_q;
    rowbuf_d     = rowbuf_q;
    bram_addr    = '0;
    bram_en      = 1'b0;
    bram_regce   = 1'b0;
    m.m_data     = '0;
    m.m_valid    = 1'b0;
    m.m_row_last = 1'b0;
    m.m_last     = 1'b0;
    done         = 1'b0;
    busy         = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_l_d = rows_clamp;
          if (num_elems == '0 || num_elems > EPR_C) begin
            elems_l_d = EPR_C;
          end else begin
            elems_l_d = num_elems;
          end
          row_d   = '0;
          elem_d  = '0;
          state_d = (rows_clamp == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        bram_en   = 1'b1;
        bram_addr = row_q;
        state_d   = S_WAIT1;
      end
      S_WAIT1: begin
        bram_regce = 1'b1;
        state_d    = S_WAIT2;
      end
      S_WAIT2: begin
        rowbuf_d = bram_dout;
        elem_d   = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        m.m_valid    = 1'b1;
        m.m_data     = rowbuf_q[ELEM_WIDTH-1:0];
        m.m_row_last = last_elem;
        m.m_last     = last_elem & last_row;
        if (hs) begin
          elem_d   = elem_q + E_ONE;
          rowbuf_d = rowbuf_q >> ELEM_WIDTH;
          if (last_elem) begin
            if (last_row) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + ADDR_W'(1);
              state_d = S_READ;
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_row_streamer.sv
// Bench for matrix_row_streamer: BRAM model, scoreboard of expected
// beats and addresses, directed transfers with backpressure and reset.
module tb_matrix_row_streamer;

  localparam int EW = 8;
  localparam int EPR = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [EW-1:0] d;
    logic          rl;
    logic          l;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [AW:0]       num_rows;
  logic [CW-1:0]     num_elems;
  logic [AW-1:0]     bram_addr;
  logic              bram_en;
  logic              bram_regce;
  logic [EW*EPR-1:0] bram_dout;
  logic              busy;
  logic              done;

  matrix_row_streamer_if #(.ELEM_WIDTH(EW)) m_if ();

  matrix_row_streamer #(
    .ELEM_WIDTH(EW),
    .ELEMS_PER_ROW(EPR),
    .RAM_DEPTH(DEPTH)
  ) dut (
    .eth_refclk(clk),
    .rst(rst),
    .start(start),
    .num_rows(num_rows),
    .num_elems(num_elems),
    .bram_addr(bram_addr),
    .bram_en(bram_en),
    .bram_regce(bram_regce),
    .bram_dout(bram_dout),
    .m(m_if),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW*EPR-1:0] mem [DEPTH];
  logic [EW*EPR-1:0] ram_lat;

  always @(posedge clk) begin
    if (bram_en) ram_lat <= mem[bram_addr];
    if (bram_regce) bram_dout <= ram_lat;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  beat_t exp_q[$];
  int    addr_q[$];

  int rdy_mode = 0;
  int rdy_idx = 0;
  int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) m_if.m_ready = 1'b1;
      else begin
        m_if.m_ready = pat[rdy_idx % 7][0];
        rdy_idx++;
      end
    end
  end

  int    cyc = 0;
  int    hs_cnt = 0;
  int    rl_cyc = 0;
  bit    pend_gap = 0;
  bit    prev_v = 0;
  bit    prev_hs = 0;
  bit    prev_done = 0;
  beat_t prev_w;
  beat_t cur_w;
  beat_t e;
  int    a;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    cur_w = {m_if.m_data, m_if.m_row_last, m_if.m_last};
    if (rst) begin
      prev_v = 0;
      prev_hs = 0;
      prev_done = 0;
      pend_gap = 0;
    end else begin
      if (bram_en) begin
        if (addr_q.size() == 0) chk("addr_extra", 1, 0);
        else begin
          a = addr_q.pop_front();
          chk("addr", 32'(bram_addr), a);
        end
      end
      if (prev_v && !prev_hs) begin
        chk("vdrop", 32'(m_if.m_valid), 1);
        chk("hold", 32'(cur_w), 32'(prev_w));
      end
      if (m_if.m_valid && !prev_v && pend_gap) begin
        chk("gap", cyc - rl_cyc, 4);
        pend_gap = 0;
      end
      if (m_if.m_valid && m_if.m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("beat_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("data", 32'(m_if.m_data), 32'(e.d));
          chk("row_last", 32'(m_if.m_row_last), 32'(e.rl));
          chk("last", 32'(m_if.m_last), 32'(e.l));
        end
        if (m_if.m_row_last && !m_if.m_last) begin
          pend_gap = 1;
          rl_cyc = cyc;
        end
      end
      if (done && prev_done) chk("done_pulse", 1, 0);
      prev_v = m_if.m_valid;
      prev_hs = m_if.m_valid && m_if.m_ready;
      prev_w = cur_w;
      prev_done = done;
    end
  end

  task automatic push_exp(input int nr, input int ne);
    int rl;
    int el;
    beat_t b;
    rl = (nr > DEPTH) ? DEPTH : nr;
    el = (ne == 0 || ne > EPR) ? EPR : ne;
    for (int r = 0; r < rl; r++) begin
      addr_q.push_back(r);
      for (int i = 0; i < el; i++) begin
        b.d = mem[r][i*EW +: EW];
        b.rl = (i == el - 1);
        b.l = (i == el - 1) && (r == rl - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run(input int nr, input int ne);
    int k;
    int lat;
    bit got_done;
    push_exp(nr, ne);
    @(posedge clk);
    #1;
    start = 1'b1;
    num_rows = (AW + 1)'(nr);
    num_elems = CW'(ne);
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 1;
    lat = -1;
    got_done = 0;
    while (k < 3000) begin
      @(negedge clk);
      if (m_if.m_valid && lat < 0) lat = k;
      if (done) begin
        got_done = 1;
        break;
      end
      k++;
    end
    chk("done_seen", 32'(got_done), 1);
    if (nr == 0) begin
      chk("done0_lat", k, 1);
      chk("no_valid", lat, -1);
    end else begin
      chk("first_lat", lat, 4);
    end
    @(negedge clk);
    chk("busy_end", 32'(busy), 0);
    chk("beats_left", exp_q.size(), 0);
    chk("addrs_left", addr_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_rows = '0;
    num_elems = '0;
    bram_dout = '0;
    ram_lat = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_if.m_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(bram_en), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 0);

    mem[0] = 32'h44332211;
    run(1, 4);

    mem[0] = 32'h04030201;
    mem[1] = 32'h08070605;
    mem[2] = 32'h0C0B0A09;
    run(3, 2);

    mem[0] = 32'h44332211;
    rdy_idx = 0;
    rdy_mode = 1;
    run(1, 4);
    run(3, 3);
    rdy_mode = 0;

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    run(2, 0);
    run(20, 4);
    run(0, 2);

    fork
      run(2, 3);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (m_if.m_valid) break;
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        num_rows = 5'd7;
        num_elems = 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join

    hs_cnt = 0;
    push_exp(3, 4);
    @(posedge clk);
    #1;
    start = 1'b1;
    num_rows = 5'd3;
    num_elems = 3'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hs_cnt >= 5) break;
    end
    chk("mid_row1", 32'(hs_cnt >= 5), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_if.m_valid), 0);
    chk("arst_data", 32'(m_if.m_data), 0);
    chk("arst_rlast", 32'(m_if.m_row_last), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_en", 32'(bram_en), 0);
    chk("arst_done", 32'(done), 0);
    repeat (2) begin
      @(negedge clk);
      chk("arst_nodone", 32'(done), 0);
    end
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(2, 4);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
